// File: rtl/stream_demux_1x2.sv
//------------------------------------------------------------------------------
// stream_demux_1x2
// Routes a valid/ready packet stream to one of two output ports. The port is
// chosen by sel on the first beat of each packet and held until the last beat.
// Each output port has a one-entry register; the two ports drain independently.
//
// Ports
//   clk                          rising-edge clock
//   reset                        synchronous active-high reset
//   din / din_valid / din_last   input beat, valid and end-of-packet
//   din_ready                    input beat accepted this cycle (combinational)
//   sel                          destination port, sampled on a packet's first beat
//   dout_x / _valid / _last      output beat on port x (registered)
//   dout_x_ready                 downstream accepts port x beat
//   busy                         packet in progress (state not IDLE)
//   pkt_cnt_x                    packets accepted for port x, wraps at 256
//------------------------------------------------------------------------------
module stream_demux_1x2 #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              din_last,
   output logic              din_ready,
   input  logic              sel,
   output logic [DATA_W-1:0] dout_0,
   output logic              dout_0_valid,
   output logic              dout_0_last,
   input  logic              dout_0_ready,
   output logic [DATA_W-1:0] dout_1,
   output logic              dout_1_valid,
   output logic              dout_1_last,
   input  logic              dout_1_ready,
   output logic              busy,
   output logic [7:0]        pkt_cnt_0,
   output logic [7:0]        pkt_cnt_1
);

   localparam int unsigned ST_W  = 2;
   localparam int unsigned CNT_W = 8;

   localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
   localparam logic [ST_W-1:0] ST_ROUTE_0 = 2'd1;
   localparam logic [ST_W-1:0] ST_ROUTE_1 = 2'd2;

   logic [ST_W-1:0]   r_state;
   logic [ST_W-1:0]   w_state_nxt;

   logic [DATA_W-1:0] r_data_0;
   logic              r_last_0;
   logic              r_valid_0;
   logic [DATA_W-1:0] r_data_1;
   logic              r_last_1;
   logic              r_valid_1;
   logic [CNT_W-1:0]  r_cnt_0;
   logic [CNT_W-1:0]  r_cnt_1;

   logic              w_active;
   logic              w_ready_0;
   logic              w_ready_1;
   logic              w_accept;
   logic              w_load_0;
   logic              w_load_1;

   // Active port: sel while idle, locked to the route once a packet is open
   always_comb begin
      w_active = 1'b0;
      case (r_state)
         ST_IDLE:    w_active = sel;
         ST_ROUTE_0: w_active = 1'b0;
         ST_ROUTE_1: w_active = 1'b1;
         default:    w_active = 1'b0;
      endcase
   end

   // A port can take a new beat if empty or its current beat leaves this edge
   assign w_ready_0 = !r_valid_0 || dout_0_ready;
   assign w_ready_1 = !r_valid_1 || dout_1_ready;

   assign din_ready = !reset && (w_active ? w_ready_1 : w_ready_0);
   assign w_accept  = din_valid && din_ready;
   assign w_load_0  = w_accept && !w_active;
   assign w_load_1  = w_accept &&  w_active;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; single-beat packets never leave IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && !din_last) begin
               w_state_nxt = sel ? ST_ROUTE_1 : ST_ROUTE_0;
            end
         end
         ST_ROUTE_0, ST_ROUTE_1: begin
            if (w_accept && din_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Port 0 output register; a load wins over a completion on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_0  <= '0;
         r_last_0  <= 1'b0;
         r_valid_0 <= 1'b0;
      end else if (w_load_0) begin
         r_data_0  <= din;
         r_last_0  <= din_last;
         r_valid_0 <= 1'b1;
      end else if (r_valid_0 && dout_0_ready) begin
         r_valid_0 <= 1'b0;
      end
   end

   // Port 1 output register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_1  <= '0;
         r_last_1  <= 1'b0;
         r_valid_1 <= 1'b0;
      end else if (w_load_1) begin
         r_data_1  <= din;
         r_last_1  <= din_last;
         r_valid_1 <= 1'b1;
      end else if (r_valid_1 && dout_1_ready) begin
         r_valid_1 <= 1'b0;
      end
   end

   // Packet counters, bumped when the last beat is accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt_0 <= '0;
         r_cnt_1 <= '0;
      end else begin
         if (w_load_0 && din_last) begin
            r_cnt_0 <= r_cnt_0 + CNT_W'(1);
         end
         if (w_load_1 && din_last) begin
            r_cnt_1 <= r_cnt_1 + CNT_W'(1);
         end
      end
   end

   assign dout_0       = r_data_0;
   assign dout_0_last  = r_last_0;
   assign dout_0_valid = r_valid_0;
   assign dout_1       = r_data_1;
   assign dout_1_last  = r_last_1;
   assign dout_1_valid = r_valid_1;
   assign busy         = (r_state != ST_IDLE);
   assign pkt_cnt_0    = r_cnt_0;
   assign pkt_cnt_1    = r_cnt_1;

endmodule

// File: tb/tb_stream_demux_1x2.sv
//------------------------------------------------------------------------------
// tb_stream_demux_1x2
// Directed bench for stream_demux_1x2. Inputs change 1 ns after the rising
// edge; outputs are checked in the same window, away from the edge.
//------------------------------------------------------------------------------
module tb_stream_demux_1x2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din;
   logic       din_valid;
   logic       din_last;
   logic       din_ready;
   logic       sel;
   logic [7:0] dout_0;
   logic       dout_0_valid;
   logic       dout_0_last;
   logic       dout_0_ready;
   logic [7:0] dout_1;
   logic       dout_1_valid;
   logic       dout_1_last;
   logic       dout_1_ready;
   logic       busy;
   logic [7:0] pkt_cnt_0;
   logic [7:0] pkt_cnt_1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stream_demux_1x2 #(.DATA_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .din          (din),
      .din_valid    (din_valid),
      .din_last     (din_last),
      .din_ready    (din_ready),
      .sel          (sel),
      .dout_0       (dout_0),
      .dout_0_valid (dout_0_valid),
      .dout_0_last  (dout_0_last),
      .dout_0_ready (dout_0_ready),
      .dout_1       (dout_1),
      .dout_1_valid (dout_1_valid),
      .dout_1_last  (dout_1_last),
      .dout_1_ready (dout_1_ready),
      .busy         (busy),
      .pkt_cnt_0    (pkt_cnt_0),
      .pkt_cnt_1    (pkt_cnt_1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; din = 8'h00; din_valid = 1'b1; din_last = 1'b1; sel = 1'b0;
      dout_0_ready = 1'b1; dout_1_ready = 1'b1;
      tick(); tick();
      n_vec++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL rst_din_ready got %b want 0", din_ready); end
      n_vec++; if ({dout_0_valid, dout_1_valid} !== 2'b00) begin n_err++; $display("FAIL rst_valid got %b want 00", {dout_0_valid, dout_1_valid}); end
      n_vec++; if ({dout_0, dout_1} !== 16'h0000) begin n_err++; $display("FAIL rst_data got %h want 0000", {dout_0, dout_1}); end
      n_vec++; if ({dout_0_last, dout_1_last, busy} !== 3'b000) begin n_err++; $display("FAIL rst_last_busy got %b want 000", {dout_0_last, dout_1_last, busy}); end
      n_vec++; if ({pkt_cnt_0, pkt_cnt_1} !== 16'h0000) begin n_err++; $display("FAIL rst_cnt got %h want 0000", {pkt_cnt_0, pkt_cnt_1}); end
      reset = 1'b0; din_valid = 1'b0; din_last = 1'b0;
      tick();
   endtask

   task automatic test_single_beat();
      sel = 1'b1; din = 8'hA5; din_last = 1'b1; din_valid = 1'b1;
      #1;
      n_vec++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", din_ready); end
      tick();
      din_valid = 1'b0; din_last = 1'b0;
      n_vec++; if ({dout_1_valid, dout_1_last, dout_1} !== {2'b11, 8'hA5}) begin n_err++; $display("FAIL single_out1 got %b%b %h want 11 a5", dout_1_valid, dout_1_last, dout_1); end
      n_vec++; if (dout_0_valid !== 1'b0) begin n_err++; $display("FAIL single_out0_valid got %b want 0", dout_0_valid); end
      n_vec++; if (pkt_cnt_1 !== 8'd1) begin n_err++; $display("FAIL single_cnt1 got %0d want 1", pkt_cnt_1); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy got %b want 0", busy); end
      tick();
      n_vec++; if (dout_1_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", dout_1_valid); end
   endtask

   task automatic test_sel_lock();
      sel = 1'b0; din = 8'h01; din_last = 1'b0; din_valid = 1'b1;
      tick();
      n_vec++; if ({dout_0_valid, dout_0} !== {1'b1, 8'h01} || busy !== 1'b1) begin n_err++; $display("FAIL lock_b1 got v%b d%h busy%b want v1 d01 busy1", dout_0_valid, dout_0, busy); end
      sel = 1'b1; din = 8'h02;
      tick();
      n_vec++; if ({dout_0_valid, dout_0_last, dout_0} !== {2'b10, 8'h02} || dout_1_valid !== 1'b0) begin n_err++; $display("FAIL lock_b2 got v%b l%b d%h v1=%b want v1 l0 d02 v1=0", dout_0_valid, dout_0_last, dout_0, dout_1_valid); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL lock_busy2 got %b want 1", busy); end
      din = 8'h03; din_last = 1'b1;
      tick();
      din_valid = 1'b0; din_last = 1'b0;
      n_vec++; if ({dout_0_valid, dout_0_last, dout_0} !== {2'b11, 8'h03} || dout_1_valid !== 1'b0) begin n_err++; $display("FAIL lock_b3 got v%b l%b d%h v1=%b want v1 l1 d03 v1=0", dout_0_valid, dout_0_last, dout_0, dout_1_valid); end
      n_vec++; if (busy !== 1'b0 || pkt_cnt_0 !== 8'd1) begin n_err++; $display("FAIL lock_end got busy%b cnt0=%0d want busy0 cnt0=1", busy, pkt_cnt_0); end
      tick();
   endtask

   task automatic test_backpressure();
      dout_0_ready = 1'b0; sel = 1'b0; din = 8'h11; din_last = 1'b0; din_valid = 1'b1;
      tick();
      din = 8'h12;
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got %b want 0", i, din_ready); end
         n_vec++; if ({dout_0_valid, dout_0} !== {1'b1, 8'h11}) begin n_err++; $display("FAIL bp_hold[%0d] got v%b d%h want v1 d11", i, dout_0_valid, dout_0); end
         tick();
      end
      dout_0_ready = 1'b1;
      #1;
      n_vec++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %b want 1", din_ready); end
      tick();
      n_vec++; if ({dout_0_valid, dout_0_last, dout_0} !== {2'b10, 8'h12}) begin n_err++; $display("FAIL bp_b2 got v%b l%b d%h want v1 l0 d12", dout_0_valid, dout_0_last, dout_0); end
      din = 8'h13; din_last = 1'b1;
      tick();
      din_valid = 1'b0; din_last = 1'b0;
      n_vec++; if ({dout_0_valid, dout_0_last, dout_0} !== {2'b11, 8'h13}) begin n_err++; $display("FAIL bp_b3 got v%b l%b d%h want v1 l1 d13", dout_0_valid, dout_0_last, dout_0); end
      n_vec++; if (pkt_cnt_0 !== 8'd2) begin n_err++; $display("FAIL bp_cnt0 got %0d want 2", pkt_cnt_0); end
      tick();
   endtask

   task automatic test_route_switch();
      dout_0_ready = 1'b0; sel = 1'b0; din = 8'h21; din_last = 1'b1; din_valid = 1'b1;
      tick();
      sel = 1'b1; din = 8'h31;
      #1;
      n_vec++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL sw_ready got %b want 1", din_ready); end
      tick();
      din_valid = 1'b0; din_last = 1'b0;
      n_vec++; if ({dout_1_valid, dout_1} !== {1'b1, 8'h31}) begin n_err++; $display("FAIL sw_out1 got v%b d%h want v1 d31", dout_1_valid, dout_1); end
      n_vec++; if ({dout_0_valid, dout_0} !== {1'b1, 8'h21}) begin n_err++; $display("FAIL sw_keep0 got v%b d%h want v1 d21", dout_0_valid, dout_0); end
      n_vec++; if ({pkt_cnt_0, pkt_cnt_1} !== {8'd3, 8'd2}) begin n_err++; $display("FAIL sw_cnt got %0d/%0d want 3/2", pkt_cnt_0, pkt_cnt_1); end
      tick();
      n_vec++; if ({dout_0_valid, dout_0, dout_1_valid} !== {1'b1, 8'h21, 1'b0}) begin n_err++; $display("FAIL sw_drain1 got v0%b d%h v1%b want v0=1 d21 v1=0", dout_0_valid, dout_0, dout_1_valid); end
      dout_0_ready = 1'b1;
      tick();
      n_vec++; if (dout_0_valid !== 1'b0) begin n_err++; $display("FAIL sw_drain0 got %b want 0", dout_0_valid); end
   endtask

   task automatic test_reset_mid_packet();
      sel = 1'b0; din = 8'h41; din_last = 1'b0; din_valid = 1'b1;
      tick();
      din = 8'h42;
      tick();
      din_valid = 1'b0; dout_0_ready = 1'b0;
      tick();
      n_vec++; if ({dout_0_valid, dout_0, busy} !== {1'b1, 8'h42, 1'b1}) begin n_err++; $display("FAIL rmp_pending got v%b d%h busy%b want v1 d42 busy1", dout_0_valid, dout_0, busy); end
      reset = 1'b1;
      #1;
      n_vec++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL rmp_ready got %b want 0", din_ready); end
      tick();
      reset = 1'b0; dout_0_ready = 1'b1;
      n_vec++; if ({dout_0_valid, dout_1_valid, busy, dout_0_last} !== 4'b0000 || dout_0 !== 8'h00) begin n_err++; $display("FAIL rmp_clear got v%b%b busy%b l%b d%h want 0000 d00", dout_0_valid, dout_1_valid, busy, dout_0_last, dout_0); end
      n_vec++; if ({pkt_cnt_0, pkt_cnt_1} !== 16'h0000) begin n_err++; $display("FAIL rmp_cnt got %h want 0000", {pkt_cnt_0, pkt_cnt_1}); end
      sel = 1'b1; din = 8'h55; din_last = 1'b1; din_valid = 1'b1;
      tick();
      din_valid = 1'b0; din_last = 1'b0;
      n_vec++; if ({dout_1_valid, dout_1_last, dout_1, dout_0_valid} !== {2'b11, 8'h55, 1'b0}) begin n_err++; $display("FAIL rmp_next got v1%b l%b d%h v0%b want 1 1 55 0", dout_1_valid, dout_1_last, dout_1, dout_0_valid); end
      n_vec++; if (pkt_cnt_1 !== 8'd1 || busy !== 1'b0) begin n_err++; $display("FAIL rmp_next_cnt got %0d busy%b want 1 busy0", pkt_cnt_1, busy); end
      tick();
   endtask

   task automatic test_counter_wrap();
      logic [7:0] exp_d;
      dout_0_ready = 1'b1; sel = 1'b0; din_last = 1'b1; din_valid = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         exp_d = 8'(i);
         din = exp_d;
         tick();
         n_vec++; if ({dout_0_valid, dout_0} !== {1'b1, exp_d}) begin n_err++; $display("FAIL wrap_data[%0d] got v%b d%h want v1 d%h", i, dout_0_valid, dout_0, exp_d); end
         if (i == 255) begin
            n_vec++; if (pkt_cnt_0 !== 8'd255) begin n_err++; $display("FAIL wrap_255 got %0d want 255", pkt_cnt_0); end
         end
         if (i == 256) begin
            n_vec++; if (pkt_cnt_0 !== 8'd0) begin n_err++; $display("FAIL wrap_256 got %0d want 0", pkt_cnt_0); end
         end
      end
      din_valid = 1'b0; din_last = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_sel_lock();
      test_backpressure();
      test_route_switch();
      test_reset_mid_packet();
      test_counter_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stream_demux_1x2.md
STREAM_DEMUX_1X2 -- requirements
Module: stream_demux_1x2

Interface
REQ-001 Parameter SHALL be: DATA_W, default 8, width of data path in bits.
REQ-002 clk  input  1  rising-edge clock; the block has only this one clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 din  input  DATA_W  input beat data.
REQ-005 din_valid  input  1  input beat present.
REQ-006 din_last  input  1  final beat of packet, qualified by din_valid.
REQ-007 din_ready  output  1  block accepts the beat this cycle.
REQ-008 sel  input  1  destination port (0 or 1), sampled only on the first beat of a packet.
REQ-009 dout_0 / dout_1  output  DATA_W  output data, ports 0 and 1.
REQ-010 dout_0_valid / dout_1_valid  output  1  output beat present.
REQ-011 dout_0_last / dout_1_last  output  1  final beat of packet.
REQ-012 dout_0_ready / dout_1_ready  input  1  downstream accepts the beat.
REQ-013 busy  output  1  high while a multi-beat packet is mid-transfer (state not IDLE).
REQ-014 pkt_cnt_0 / pkt_cnt_1  output  8  count of packets accepted for each port.

Function
REQ-015 Transfer rule: an input beat is accepted when din_valid && din_ready at a rising clk edge. An output beat on port x completes when dout_x_valid && dout_x_ready.
REQ-016 FSM states SHALL be IDLE, ROUTE_0 and ROUTE_1.
REQ-017 Active port: in IDLE, active port = sel (combinational). In ROUTE_x, active port = x and sel is ignored.
REQ-018 IDLE transitions: accepted beat with din_last=0 -> ROUTE_sel. Accepted beat with din_last=1 (single-beat packet) -> stay IDLE. No accept -> stay IDLE.
REQ-019 ROUTE_x transitions: accepted beat with din_last=1 -> IDLE. Otherwise stay ROUTE_x.
REQ-020 Each port SHALL have a one-entry output register holding dout_x, dout_x_last and dout_x_valid.
REQ-021 din_ready SHALL equal (!dout_a_valid || dout_a_ready), where a is the active port. din_ready is combinational from dout_a_ready and does not depend on din_valid.
REQ-022 An accepted beat SHALL load the active port register on the same edge.
  - dout_a_valid goes high the next cycle, so latency is 1 cycle.
  - Throughput is 1 beat/cycle when the downstream holds ready high.
REQ-023 Port register with no new load: completion clears dout_x_valid. While dout_x_valid && !dout_x_ready, dout_x and dout_x_last SHALL hold stable.
REQ-024 Inactive port register SHALL drain independently. Its pending beat is neither lost nor duplicated when the route switches.
REQ-025 A beat SHALL never be presented on both ports. Beats of one packet SHALL all go to one port, in order.
REQ-026 pkt_cnt_x SHALL increment by 1 on each accepted beat with din_last=1 routed to x. It counts at accept time, not at output time, and wraps 255 -> 0.
REQ-027 Simultaneous completion and load on the same port in the same edge SHALL replace the register contents, and valid stays high.
REQ-028 busy SHALL be 1 in ROUTE_0/ROUTE_1 and 0 in IDLE.

Reset
REQ-029 While reset=1 at an edge, the following SHALL hold next cycle:
  - state=IDLE, busy=0.
  - dout_0_valid=dout_1_valid=0.
  - dout_0=dout_1=0, dout_0_last=dout_1_last=0.
  - pkt_cnt_0=pkt_cnt_1=0.
REQ-030 Reset mid-packet SHALL discard pending output beats and the partial route.
REQ-031 The first beat after reset SHALL be treated as a new packet and sample sel.
REQ-032 During reset, din_ready SHALL be 0.

Verification
REQ-033 Single-beat routing:
  - Stimulus: sel=1, din=0xA5, last=1, valid for 1 cycle; both readies =1.
  - Response: dout_1=0xA5 valid with last=1 exactly 1 cycle later; dout_0_valid stays 0; pkt_cnt_1=1; busy stays 0.
REQ-034 Sel locked mid-packet:
  - Stimulus: 3-beat packet 0x01,0x02,0x03 with sel=0 on beat 1; sel toggled to 1 on beats 2-3.
  - Response: all 3 beats appear on port 0 in order; busy=1 after beat 1 and 0 after beat 3; pkt_cnt_0=1.
REQ-035 Backpressure:
  - Stimulus: dout_0_ready=0 for 4 cycles during a packet to port 0.
  - Response: din_ready=0 after the first beat loads; dout_0 holds its value stable; no beat is lost once ready=1.
REQ-036 Route switch with pending beat:
  - Stimulus: port 0 holds a beat with ready=0; a new single-beat packet arrives with sel=1.
  - Response: it is accepted and emitted on port 1; the port 0 beat is retained and emitted once dout_0_ready=1.
REQ-037 Reset mid-packet:
  - Stimulus: reset pulses 1 cycle after beat 2 of a 4-beat packet.
  - Response: all outputs return to reset values; the next beat with sel=1 and last=1 goes to port 1; pkt_cnt_1=1.
REQ-038 Counter wrap:
  - Stimulus: 256 single-beat packets to port 0.
  - Response: pkt_cnt_0=0 after packet 256, having read 255 after packet 255.
